alu_issue_ctrl: RTL and testbench

Issue and collection controller on the requesting side of the two-cycle execute ALU. It accepts decoded ALU operations from the decode stage over a valid/ready handshake and drives the ALU operand and function inputs. It also captures the ALU result during the single cycle it is valid and buffers results toward writeback with a second valid/ready handshake. Issue is credit-limited so no ALU result is ever lost under writeback backpressure. The block supports a synchronous pipeline flush.

---
 rtl/alu_issue_ctrl.sv | 107 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/collection controller for the two-cycle execute ALU: passes decoded ops to
// the ALU, captures each result in its single valid cycle, and buffers results for writeback.
module alu_issue_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_function,
    input  logic        in_modifier,
    input  logic [4:0]  in_rd,
    output logic [31:0] alu_input_a,
    output logic [31:0] alu_input_b,
    output logic [2:0]  alu_function_select,
    output logic        alu_function_modifier,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
    } entry_t;

    typedef logic [CW:0] occ_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            inflight_valid;
    logic [4:0]      inflight_rd;

    logic            issue;
    logic            push;
    logic            pop;
    logic            pop_raw;
    occ_t            outstanding;

    assign alu_input_a           = in_a;
    assign alu_input_b           = in_b;
    assign alu_function_select   = in_function;
    assign alu_function_modifier = in_modifier;

    assign out_valid  = (count != '0);
    assign out_result = mem[rd_ptr].result;
    assign out_rd     = mem[rd_ptr].rd;

    // Credits cover the in-flight op as well, so a capture always finds a free slot.
    assign pop_raw     = out_valid && out_ready;
    assign outstanding = occ_t'(count) + occ_t'(inflight_valid) - occ_t'(pop_raw);
    assign in_ready    = !flush && (outstanding < occ_t'(DEPTH));

    assign issue = in_valid && in_ready;
    assign push  = inflight_valid && !flush;
    assign pop   = pop_raw && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_valid <= 1'b0;
            inflight_rd    <= '0;
        end else begin
            inflight_valid <= issue;
            inflight_rd    <= issue ? in_rd : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: entries are reset so out_result/out_rd read 0 after reset rather than X.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{result: alu_result, rd: inflight_rd};
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural two-cycle ALU drives alu_result,
// expected results are queued at issue and compared by a negedge monitor.
module tb_alu_issue_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_function = '0;
    logic        in_modifier = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] alu_input_a;
    logic [31:0] alu_input_b;
    logic [2:0]  alu_function_select;
    logic        alu_function_modifier;
    logic [31:0] alu_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .flush                 (flush),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_a                  (in_a),
        .in_b                  (in_b),
        .in_function           (in_function),
        .in_modifier           (in_modifier),
        .in_rd                 (in_rd),
        .alu_input_a           (alu_input_a),
        .alu_input_b           (alu_input_b),
        .alu_function_select   (alu_function_select),
        .alu_function_modifier (alu_function_modifier),
        .alu_result            (alu_result),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_result            (out_result),
        .out_rd                (out_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          avail;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] fn, input logic mod);
        case (fn)
            3'd0:    return mod ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, $signed(a) < $signed(b)};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return mod ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return mod ? a & ~b : a & b;
        endcase
    endfunction

    // Behavioural ALU: samples its inputs every edge, result valid the following cycle.
    always @(posedge clk) begin
        alu_result <= alu_fn(alu_input_a, alu_input_b, alu_function_select, alu_function_modifier);
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: order of evaluation is pop, then issue, so a same-edge push never feeds the pop.
    logic exp_valid, exp_pop, exp_ready;
    exp_t head;
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            exp_valid = (exp_q.size() != 0) && (exp_q[0].avail <= cyc);
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            exp_pop   = exp_valid && out_ready && !flush;
            exp_ready = !flush && ((exp_q.size() - (exp_pop ? 1 : 0)) < DEPTH);
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_pop) begin
                    head = exp_q.pop_front();
                    check("out_result", 64'(out_result), 64'(head.result));
                    check("out_rd", 64'(out_rd), 64'(head.rd));
                end
                if (in_valid && in_ready)
                    exp_q.push_back('{alu_fn(in_a, in_b, in_function, in_modifier), in_rd, cyc + 2});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] fn,
                           input logic mod, input logic [4:0] rd);
        logic acc;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_function = fn; in_modifier = mod; in_rd = rd;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("issue_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_result"}, 64'(out_result), 64'(0));
        check({tag, "_out_rd"}, 64'(out_rd), 64'(0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    int accepted;

    initial begin
        // Reset state
        #12;
        check_idle("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        step();
        check_idle("post_reset");

        // Single op: 5 - 3 = 2, tag 7, visible exactly two cycles after issue
        out_ready = 1'b0;
        send_op(32'd5, 32'd3, 3'b000, 1'b1, 5'd7);
        @(negedge clk);
        check("single_early_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_result", 64'(out_result), 64'(2));
        check("single_rd", 64'(out_rd), 64'(7));
        step();
        out_ready = 1'b1;
        step();
        check("single_popped", 64'(out_valid), 64'(0));

        // Streaming: 16 back-to-back adds, results 1..16
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_op(32'(i), 32'd1, 3'b000, 1'b0, 5'(i));
        drain();

        // Backpressure: only DEPTH ops accepted while writeback stalls
        out_ready = 1'b0;
        send_op(32'd100, 32'd1, 3'b000, 1'b0, 5'd1);
        send_op(32'd200, 32'd1, 3'b000, 1'b0, 5'd2);
        in_valid = 1'b1; in_a = 32'd300; in_b = 32'd1; in_function = 3'b000; in_modifier = 1'b0; in_rd = 5'd3;
        accepted = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (in_ready) accepted++;
            step();
        end
        check("bp_extra_accepts", 64'(accepted), 64'(0));
        out_ready = 1'b1;
        send_op(32'd300, 32'd1, 3'b000, 1'b0, 5'd3);
        send_op(32'd400, 32'd1, 3'b000, 1'b0, 5'd4);
        drain();

        // Concurrent push/pop over several pointer wraps with mixed functions
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++)
            send_op($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom), 5'(i + 8));
        drain();

        // Flush with one op buffered and one in flight
        out_ready = 1'b0;
        send_op(32'hAAAA, 32'h1111, 3'b100, 1'b0, 5'd20);
        send_op(32'hBBBB, 32'h2222, 3'b110, 1'b0, 5'd21);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'(0));
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready_after", 64'(in_ready), 64'(1));
        step();
        step();
        check("flush_no_stale", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        send_op(32'd40, 32'd2, 3'b000, 1'b0, 5'd22);
        drain();

        // Randomized traffic with occasional flush
        for (int k = 0; k < 400; k++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_a        = $urandom;
            in_b        = $urandom;
            in_function = 3'($urandom_range(0, 7));
            in_modifier = 1'($urandom);
            in_rd       = 5'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 29) == 0);
            step();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        drain();

        // Asynchronous reset between edges with work outstanding
        out_ready = 1'b0;
        send_op(32'd7, 32'd8, 3'b000, 1'b0, 5'd9);
        send_op(32'd9, 32'd8, 3'b000, 1'b0, 5'd10);
        step();
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        step();
        step();
        reset_n = 1'b1;
        step();
        check_idle("after_async_reset");
        out_ready = 1'b1;
        send_op(32'd50, 32'd8, 3'b000, 1'b1, 5'd31);
        @(negedge clk);
        @(negedge clk);
        check("fresh_result", 64'(out_result), 64'(42));
        check("fresh_rd", 64'(out_rd), 64'(31));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
